// File: rtl/sevenseg_scan_driver.sv
// rtl/sevenseg_scan_driver.sv - binary-to-BCD shift-add-3 converter feeding a multiplexed active-low 7-segment scan
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits above digit 0)
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS = 2,
  parameter int VALUE_W    = 6,
  parameter int SCAN_DIV   = 50000
) (
  input  logic               CLK100MHZ,
  input  logic               RESET,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               blank,
  output logic               busy,
  output logic [7:0]         AN,
  output logic [6:0]         display
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  localparam int          BCD_W   = 4 * NUM_DIGITS;
  localparam int          STEP_W  = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam int          SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int          IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [STEP_W-1:0]        r_step;
  logic [VALUE_W-1:0]       r_bin;
  logic [BCD_W-1:0]         r_work;
  logic                     r_ovf_work;
  logic                     r_pend_vld;
  logic [VALUE_W-1:0]       r_pend_val;
  logic [BCD_W-1:0]         r_shown;
  logic                     r_ovf;
  logic [SLOT_W-1:0]        r_slot;
  logic [IDX_W-1:0]         r_idx;
  logic [7:0]               r_an;
  logic [6:0]               r_disp;

  logic                     w_start;
  logic [VALUE_W-1:0]       w_start_val;
  logic                     w_ovf_in;
  logic [BCD_W-1:0]         w_adj;
  logic [BCD_W+VALUE_W-1:0] w_cat_sh;
  logic                     w_tick;
  logic [3:0]               w_nibble;
  logic [6:0]               w_seg;

  // A load seen in COMMIT is newer than any pending one, so it wins.
  assign w_start     = ((r_state == S_IDLE) && load) ||
                       ((r_state == S_COMMIT) && (load || r_pend_vld));
  assign w_start_val = ((r_state == S_COMMIT) && !load) ? r_pend_val : value;
  assign w_ovf_in    = (64'(w_start_val) > MAX_VAL);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (load) w_state_nxt = S_CONV;
      S_CONV:   if (r_step == STEP_W'(VALUE_W - 1)) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = (load || r_pend_vld) ? S_CONV : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_work;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_work[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
    end
    w_cat_sh = {w_adj, r_bin} << 1;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_step     <= '0;
      r_bin      <= '0;
      r_work     <= '0;
      r_ovf_work <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_val <= '0;
      r_shown    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_bin      <= w_start_val;
        r_work     <= '0;
        r_step     <= '0;
        r_ovf_work <= w_ovf_in;
      end else if (r_state == S_CONV) begin
        r_work <= w_cat_sh[BCD_W+VALUE_W-1:VALUE_W];
        r_bin  <= w_cat_sh[VALUE_W-1:0];
        r_step <= r_step + STEP_W'(1);
      end
      if (r_state == S_COMMIT) begin
        r_shown    <= r_work;
        r_ovf      <= r_ovf_work;
        r_pend_vld <= 1'b0;
      end else if ((r_state == S_CONV) && load) begin
        r_pend_vld <= 1'b1;
        r_pend_val <= value;
      end
    end
  end

  assign w_tick   = (r_slot == SLOT_W'(SCAN_DIV - 1));
  assign w_nibble = r_shown[{r_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic w_upper_zero;
  assign w_upper_zero = ((r_shown >> {r_idx, 2'b00}) == '0);
`endif

  always_comb begin
    w_seg = seg_decode(w_nibble);
`ifdef LEADING_ZERO_BLANK_EN
    if ((r_idx != '0) && w_upper_zero) w_seg = 7'b1111111;
`endif
    if (r_ovf) w_seg = 7'b1111110;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      r_slot <= '0;
      r_idx  <= '0;
      r_an   <= 8'hFF;
      r_disp <= 7'h7F;
    end else if (w_tick) begin
      r_slot <= '0;
      r_an   <= blank ? 8'hFF : ~(8'h01 << r_idx);
      r_disp <= w_seg;
      r_idx  <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_slot <= r_slot + SLOT_W'(1);
    end
  end

  assign busy    = (r_state == S_CONV);
  assign AN      = r_an;
  assign display = r_disp;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb/tb_sevenseg_scan_driver.sv - randomized bench with decimal-arithmetic reference model for sevenseg_scan_driver
module tb_sevenseg_scan_driver;
  localparam int ND = 2;
  localparam int VW = 7;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          RESET = 1'b1;
  logic          load = 1'b0;
  logic          blank = 1'b0;
  logic [VW-1:0] value = '0;
  logic          busy;
  logic [7:0]    AN;
  logic [6:0]    display;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  sevenseg_scan_driver #(.NUM_DIGITS(ND), .VALUE_W(VW), .SCAN_DIV(SD)) dut (
    .CLK100MHZ(clk), .RESET(RESET), .value(value), .load(load), .blank(blank),
    .busy(busy), .AN(AN), .display(display)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // Reference model: decimal value plus cycle counters
  int         m_shown, m_val, m_pval, m_cnt, m_slot, m_idx;
  bit         m_ovf, m_act, m_pend;
  logic [7:0] m_an;
  logic [6:0] m_disp;

  function automatic int pow10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] exp_seg(input int i);
    int d;
    d = (m_shown / pow10(i)) % 10;
    if (m_ovf) return 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && (m_shown / pow10(i)) == 0) return 7'b1111111;
`endif
    return seg_tab[d];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (RESET) begin
      m_act <= 0; m_cnt <= 0; m_val <= 0; m_pend <= 0; m_pval <= 0;
      m_shown <= 0; m_ovf <= 0; m_slot <= 0; m_idx <= 0;
      m_an <= 8'hFF; m_disp <= 7'h7F;
    end else begin
      if (m_slot == SD - 1) begin
        m_slot <= 0;
        m_an   <= blank ? 8'hFF : ~(8'h01 << m_idx);
        m_disp <= exp_seg(m_idx);
        m_idx  <= (m_idx + 1) % ND;
      end else begin
        m_slot <= m_slot + 1;
      end
      if (m_act && m_cnt == VW) begin
        m_shown <= m_val;
        m_ovf   <= (m_val > pow10(ND) - 1);
        m_pend  <= 0;
        if (load) begin m_cnt <= 0; m_val <= int'(value); end
        else if (m_pend) begin m_cnt <= 0; m_val <= m_pval; end
        else m_act <= 0;
      end else if (m_act) begin
        m_cnt <= m_cnt + 1;
        if (load) begin m_pend <= 1; m_pval <= int'(value); end
      end else if (load) begin
        m_act <= 1; m_cnt <= 0; m_val <= int'(value);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", busy, (m_act && m_cnt < VW) ? 1 : 0);
      check("model_an", AN, m_an);
      if (m_an != 8'hFF) check("model_display", display, m_disp);
    end
  end

  task automatic do_load(input int v);
    value = VW'(v);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic settle();
    repeat (VW + 3) @(negedge clk);
  endtask

  // Wait for a fresh slot of anode pattern a, then pin its segments.
  task automatic see(input string name, input logic [7:0] a, input logic [6:0] d);
    for (int n = 0; n < 40 && AN == a; n++) @(negedge clk);
    for (int n = 0; n < 40 && AN != a; n++) @(negedge clk);
    check({name, "_an"}, AN, a);
    check({name, "_seg"}, display, d);
  endtask

  initial begin
    int nb;
    RESET = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_an", AN, 8'hFF);
    check("rst_seg", display, 7'h7F);
    check("rst_busy", busy, 0);
    RESET = 1'b0;
    for (int n = 0; n < 10 && AN == 8'hFF; n++) @(negedge clk);
    check("first_an", AN, 8'hFE);
    check("first_seg", display, 7'b0000001);

    do_load(42);
    nb = 0;
    while (busy && nb < 40) begin nb++; @(negedge clk); end
    check("busy_len", nb, VW);
    settle();
    see("v42_d0", 8'hFE, 7'b0010010);
    see("v42_d1", 8'hFD, 7'b1001100);

    do_load(5);
    settle();
    see("v5_d0", 8'hFE, 7'b0100100);
`ifdef LEADING_ZERO_BLANK_EN
    see("v5_d1", 8'hFD, 7'b1111111);
`else
    see("v5_d1", 8'hFD, 7'b0000001);
`endif

    do_load(120);
    settle();
    see("ovf_d0", 8'hFE, 7'b1111110);
    see("ovf_d1", 8'hFD, 7'b1111110);
    do_load(99);
    settle();
    see("v99_d0", 8'hFE, 7'b0000100);
    see("v99_d1", 8'hFD, 7'b0000100);

    do_load(12);
    @(negedge clk);
    do_load(34);
    nb = 0;
    while (busy && nb < 40) begin nb++; @(negedge clk); end
    @(negedge clk);
    check("pend_restart", busy, 1);
    settle();
    check("pend_done", busy, 0);
    see("v34_d0", 8'hFE, 7'b1001100);
    see("v34_d1", 8'hFD, 7'b0000110);

    do_load(57);
    repeat (2) @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_an", AN, 8'hFF);
    value = VW'(77);
    load  = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    load  = 1'b0;
    check("rstload_busy", busy, 0);
    settle();
    see("rst_d0", 8'hFE, 7'b0000001);
`ifdef LEADING_ZERO_BLANK_EN
    see("rst_d1", 8'hFD, 7'b1111111);
`else
    see("rst_d1", 8'hFD, 7'b0000001);
`endif

    blank = 1'b1;
    repeat (SD + 1) @(negedge clk);
    check("blank_an", AN, 8'hFF);
    repeat (20 - SD - 1) @(negedge clk);
    blank = 1'b0;
    repeat (2 * SD) @(negedge clk);

    for (int c = 0; c < 3000; c++) begin
      RESET = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 5) == 0);
      value = VW'($urandom_range(0, 127));
      if ($urandom_range(0, 39) == 0) blank = ~blank;
      @(negedge clk);
    end
    RESET = 1'b0;
    load  = 1'b0;
    blank = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
